// File: rtl/exec_core.sv
// exec_core: instruction register and field decoder, multi-cycle control
// sequencer, 8-function ALU with registered result, plus the register-file
// store-value mux and the instruction-pointer adjust mux.
//
// Handshake note: there is no valid/ready protocol here. The phase strobes
// are one-hot Moore outputs. Each neighbouring block acts on the cycle its
// strobe is high. instr must be valid whenever do_fetch is high.
// regval1/regval2 must be valid whenever do_aluop is high.
module exec_core #(
    parameter int WORD_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int NIB_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  do_reset,
    input  logic [WORD_WIDTH-1:0] instr,
    input  logic [WORD_WIDTH-1:0] regval1,
    input  logic [WORD_WIDTH-1:0] regval2,
    output logic                  do_fetch,
    output logic                  do_regload,
    output logic                  do_aluop,
    output logic                  do_regstore,
    output logic                  do_next,
    output logic [NIB_WIDTH-1:0]  opcode,
    output logic [NIB_WIDTH-1:0]  reg1,
    output logic [NIB_WIDTH-1:0]  reg2,
    output logic [NIB_WIDTH-1:0]  reg3,
    output logic [BYTE_WIDTH-1:0] bigval,
    output logic [NIB_WIDTH-1:0]  smallval,
    output logic                  isaluop,
    output logic [2:0]            aluop,
    output logic [WORD_WIDTH-1:0] aluout,
    output logic                  zero,
    output logic [WORD_WIDTH-1:0] storeval,
    output logic [WORD_WIDTH-1:0] pointer_adj,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        ST_RST      = 3'd0,
        ST_FETCH    = 3'd1,
        ST_REGLOAD  = 3'd2,
        ST_ALUOP    = 3'd3,
        ST_REGSTORE = 3'd4,
        ST_NEXT     = 3'd5
    } state_t;

    localparam logic [NIB_WIDTH-1:0] OP_LOADLO = 4'h1;
    localparam logic [NIB_WIDTH-1:0] OP_JMP    = 4'h2;

    state_t                state_q;
    logic [WORD_WIDTH-1:0] ir_q;
    logic [WORD_WIDTH-1:0] aluout_q;
    logic [WORD_WIDTH-1:0] alu_d;
    logic                  fetch_q, regload_q, aluop_q, regstore_q, next_q;

    // Sequencer: state plus registered one-hot strobes tracking the new state.
    always_ff @(posedge clk or posedge do_reset) begin
        if (do_reset) begin
            state_q    <= ST_RST;
            fetch_q    <= 1'b0;
            regload_q  <= 1'b0;
            aluop_q    <= 1'b0;
            regstore_q <= 1'b0;
            next_q     <= 1'b0;
        end else begin
            fetch_q    <= 1'b0;
            regload_q  <= 1'b0;
            aluop_q    <= 1'b0;
            regstore_q <= 1'b0;
            next_q     <= 1'b0;
            case (state_q)
                ST_RST: begin
                    state_q <= ST_FETCH;
                    fetch_q <= 1'b1;
                end
                ST_FETCH: begin
                    // Branch on the word being latched, not on the old IR.
                    if (instr[15]) begin
                        state_q   <= ST_REGLOAD;
                        regload_q <= 1'b1;
                    end else if (instr[15:12] == OP_LOADLO) begin
                        state_q    <= ST_REGSTORE;
                        regstore_q <= 1'b1;
                    end else begin
                        state_q <= ST_NEXT;
                        next_q  <= 1'b1;
                    end
                end
                ST_REGLOAD: begin
                    state_q <= ST_ALUOP;
                    aluop_q <= 1'b1;
                end
                ST_ALUOP: begin
                    state_q    <= ST_REGSTORE;
                    regstore_q <= 1'b1;
                end
                ST_REGSTORE: begin
                    state_q <= ST_NEXT;
                    next_q  <= 1'b1;
                end
                ST_NEXT: begin
                    state_q <= ST_FETCH;
                    fetch_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RST;
                end
            endcase
        end
    end

    // Instruction register: captured on the edge that leaves FETCH only.
    always_ff @(posedge clk or posedge do_reset) begin
        if (do_reset) begin
            ir_q <= '0;
        end else if (state_q == ST_FETCH) begin
            ir_q <= instr;
        end
    end

    // ALU function select; shifts use only the low nibble of b.
    always_comb begin
        alu_d = '0;
        case (ir_q[14:12])
            3'd0: alu_d = regval1 + regval2;
            3'd1: alu_d = regval1 - regval2;
            3'd2: alu_d = regval1 & regval2;
            3'd3: alu_d = regval1 | regval2;
            3'd4: alu_d = regval1 ^ regval2;
            3'd5: alu_d = ~regval1;
            3'd6: alu_d = regval1 << regval2[3:0];
            3'd7: alu_d = regval1 >> regval2[3:0];
            default: alu_d = '0;
        endcase
    end

    // ALU result register: updates only on the edge leaving ALUOP.
    always_ff @(posedge clk or posedge do_reset) begin
        if (do_reset) begin
            aluout_q <= '0;
        end else if (state_q == ST_ALUOP) begin
            aluout_q <= alu_d;
        end
    end

    assign do_fetch    = fetch_q;
    assign do_regload  = regload_q;
    assign do_aluop    = aluop_q;
    assign do_regstore = regstore_q;
    assign do_next     = next_q;
    assign state_dbg   = state_q;

    assign opcode   = ir_q[15:12];
    assign reg1     = ir_q[11:8];
    assign reg2     = ir_q[7:4];
    assign reg3     = ir_q[3:0];
    assign bigval   = ir_q[7:0];
    assign smallval = ir_q[3:0];
    assign isaluop  = ir_q[15];
    assign aluop    = ir_q[14:12];

    assign aluout = aluout_q;
    assign zero   = (aluout_q == '0);

    // LOADLO stores the zero-extended immediate; everything else stores the ALU result.
    assign storeval    = (opcode == OP_LOADLO) ? {8'h00, bigval} : aluout_q;
    // JMP moves the pointer back by a sign-extended-negative offset; otherwise step by one.
    assign pointer_adj = (opcode == OP_JMP) ? {8'hFF, bigval} : 16'h0001;

endmodule

// File: tb/tb_exec_core.sv
// Directed testbench for exec_core.
module tb_exec_core;

    logic        clk;
    logic        do_reset;
    logic [15:0] instr;
    logic [15:0] regval1;
    logic [15:0] regval2;
    logic        do_fetch, do_regload, do_aluop, do_regstore, do_next;
    logic [3:0]  opcode, reg1, reg2, reg3, smallval;
    logic [7:0]  bigval;
    logic        isaluop;
    logic [2:0]  aluop;
    logic [15:0] aluout;
    logic        zero;
    logic [15:0] storeval;
    logic [15:0] pointer_adj;
    logic [2:0]  state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    // Strobe vector order: {fetch, regload, aluop, regstore, next}
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_FETCH = 5'b10000;
    localparam logic [4:0] S_RLOAD = 5'b01000;
    localparam logic [4:0] S_ALU   = 5'b00100;
    localparam logic [4:0] S_STORE = 5'b00010;
    localparam logic [4:0] S_NEXT  = 5'b00001;

    exec_core dut (
        .clk         (clk),
        .do_reset    (do_reset),
        .instr       (instr),
        .regval1     (regval1),
        .regval2     (regval2),
        .do_fetch    (do_fetch),
        .do_regload  (do_regload),
        .do_aluop    (do_aluop),
        .do_regstore (do_regstore),
        .do_next     (do_next),
        .opcode      (opcode),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg3        (reg3),
        .bigval      (bigval),
        .smallval    (smallval),
        .isaluop     (isaluop),
        .aluop       (aluop),
        .aluout      (aluout),
        .zero        (zero),
        .storeval    (storeval),
        .pointer_adj (pointer_adj),
        .state_dbg   (state_dbg)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_strobes(input string tag, input logic [4:0] exp);
        chk(tag, {11'd0, do_fetch, do_regload, do_aluop, do_regstore, do_next}, {11'd0, exp});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs a full ALU instruction starting with the core in FETCH.
    task automatic run_alu(input string tag, input logic [15:0] ins,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp);
        instr = ins; regval1 = a; regval2 = b;
        step(); chk_strobes({tag, "_regload"}, S_RLOAD);
        step(); chk_strobes({tag, "_aluop"}, S_ALU);
        step(); chk_strobes({tag, "_regstore"}, S_STORE);
        chk({tag, "_aluout"}, aluout, exp);
        chk({tag, "_storeval"}, storeval, exp);
        chk({tag, "_zero"}, {15'd0, zero}, {15'd0, exp == 16'h0000});
        step(); chk_strobes({tag, "_next"}, S_NEXT);
        chk({tag, "_ptradj"}, pointer_adj, 16'h0001);
        step(); chk_strobes({tag, "_fetch"}, S_FETCH);
    endtask

    initial begin
        do_reset = 1'b1;
        instr = 16'h0000;
        regval1 = 16'h0000;
        regval2 = 16'h0000;
        #2;
        chk_strobes("rst_strobes", S_NONE);
        chk("rst_aluout", aluout, 16'h0000);
        chk("rst_zero", {15'd0, zero}, 16'h0001);
        chk("rst_ir", {opcode, reg1, reg2, reg3}, 16'h0000);
        step(); step();
        chk_strobes("rst_hold", S_NONE);
        do_reset = 1'b0;
        step(); chk_strobes("post_rst_fetch", S_FETCH);

        // ADD 0x8123: 5 + 7
        instr = 16'h8123; regval1 = 16'h0005; regval2 = 16'h0007;
        step(); chk_strobes("add_regload", S_RLOAD);
        chk("add_reg1", {12'd0, reg1}, 16'h0001);
        chk("add_reg2", {12'd0, reg2}, 16'h0002);
        chk("add_reg3", {12'd0, reg3}, 16'h0003);
        chk("add_isalu", {15'd0, isaluop}, 16'h0001);
        chk("add_aluop", {13'd0, aluop}, 16'h0000);
        chk("add_bigval", {8'd0, bigval}, 16'h0023);
        chk("add_small", {12'd0, smallval}, 16'h0003);
        step(); chk_strobes("add_aluop_st", S_ALU);
        chk("add_aluout_pre", aluout, 16'h0000);
        step(); chk_strobes("add_regstore", S_STORE);
        chk("add_aluout", aluout, 16'h000C);
        chk("add_storeval", storeval, 16'h000C);
        chk("add_zero", {15'd0, zero}, 16'h0000);
        step(); chk_strobes("add_next", S_NEXT);
        chk("add_ptradj", pointer_adj, 16'h0001);
        step(); chk_strobes("add_fetch", S_FETCH);

        // SUB wrap and SUB to zero
        run_alu("sub_wrap", 16'h9412, 16'h0000, 16'h0001, 16'hFFFF);
        chk("sub_wrap_reg1", {12'd0, reg1}, 16'h0004);
        run_alu("sub_zero", 16'h9412, 16'h0003, 16'h0003, 16'h0000);
        run_alu("add_wrap", 16'h8000, 16'hFFFF, 16'h0002, 16'h0001);

        // LOADLO 0x15AB: fetch, regstore, next
        instr = 16'h15AB;
        step(); chk_strobes("ld_regstore", S_STORE);
        chk("ld_reg1", {12'd0, reg1}, 16'h0005);
        chk("ld_storeval", storeval, 16'h00AB);
        chk("ld_aluout", aluout, 16'h0001);
        chk("ld_ptradj", pointer_adj, 16'h0001);
        step(); chk_strobes("ld_next", S_NEXT);
        chk("ld_aluout_keep", aluout, 16'h0001);
        step(); chk_strobes("ld_fetch", S_FETCH);

        // JMP 0x20FC: fetch, next
        instr = 16'h20FC;
        step(); chk_strobes("jmp_next", S_NEXT);
        chk("jmp_ptradj", pointer_adj, 16'hFFFC);
        chk("jmp_storeval", storeval, 16'h0001);
        step(); chk_strobes("jmp_fetch", S_FETCH);

        // NOP 0x0000 and 0x7FFF treated as NOP
        instr = 16'h0000;
        step(); chk_strobes("nop_next", S_NEXT);
        chk("nop_ptradj", pointer_adj, 16'h0001);
        step(); chk_strobes("nop_fetch", S_FETCH);
        instr = 16'h7FFF;
        step(); chk_strobes("op7_next", S_NEXT);
        chk("op7_ptradj", pointer_adj, 16'h0001);
        step(); chk_strobes("op7_fetch", S_FETCH);

        // Shift and logic ops with a=0x00F0, b=0x0014
        run_alu("shl", 16'hE123, 16'h00F0, 16'h0014, 16'h0F00);
        run_alu("shr", 16'hF123, 16'h00F0, 16'h0014, 16'h000F);
        run_alu("and", 16'hA123, 16'h00F0, 16'h0014, 16'h0010);
        run_alu("or",  16'hB123, 16'h00F0, 16'h0014, 16'h00F4);
        run_alu("xor", 16'hC123, 16'h00F0, 16'h0014, 16'h00E4);
        run_alu("not", 16'hD123, 16'h00F0, 16'h0014, 16'hFF0F);

        // Reset in the middle of ALUOP
        instr = 16'h8123; regval1 = 16'h1111; regval2 = 16'h2222;
        step(); chk_strobes("mid_regload", S_RLOAD);
        step(); chk_strobes("mid_aluop", S_ALU);
        do_reset = 1'b1;
        #1;
        chk_strobes("mid_rst_strobes", S_NONE);
        chk("mid_rst_aluout", aluout, 16'h0000);
        chk("mid_rst_zero", {15'd0, zero}, 16'h0001);
        chk("mid_rst_ir", {opcode, reg1, reg2, reg3}, 16'h0000);
        step();
        chk_strobes("mid_rst_hold", S_NONE);
        chk("mid_rst_aluout_hold", aluout, 16'h0000);
        instr = 16'h0000;
        do_reset = 1'b0;
        step(); chk_strobes("mid_rel_fetch", S_FETCH);
        step(); chk_strobes("mid_rel_next", S_NEXT);
        step(); chk_strobes("mid_rel_fetch2", S_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
